// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial feeder: default word width, state encoding and
// length normalisation.
package seq_pkg;

  localparam int unsigned SEQ_WORD_W = 8;
  localparam int unsigned SEQ_LEN_W  = $clog2(SEQ_WORD_W) + 1;

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_e;

  // A length of zero or one beyond the word width selects the full word.
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_word_buf.sv
// One-entry holding register for a word waiting behind the shifter.
module seq_word_buf #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              take,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic [WORD_W-1:0] data,
  output logic [LEN_W-1:0]  len,
  output logic              full
);

  logic [WORD_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              full_q, full_d;

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    full_d = full_q;
    if (load) begin
      data_d = load_data;
      len_d  = load_len;
      full_d = 1'b1;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      len_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign len  = len_q;
  assign full = full_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: takes words over valid/ready and emits them MSB-first on x,
// with a one-word pending buffer for gapless streaming.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WORD_W   = SEQ_WORD_W,
  parameter logic        IDLE_BIT = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     din,
  input  logic [$clog2(WORD_W):0] din_len,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  x,
  output logic                  x_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      words_sent
);

  localparam int unsigned LEN_W = $clog2(WORD_W) + 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              x_q, x_d;
  logic              xv_q, xv_d;

  logic              accept;
  logic              direct_load;
  logic              pend_load;
  logic              pend_take;
  logic              pend_full;
  logic [WORD_W-1:0] pend_data;
  logic [LEN_W-1:0]  pend_len;
  logic [LEN_W-1:0]  in_len;
  logic [WORD_W-1:0] in_word;

  assign din_ready = !pend_full;
  assign accept    = din_valid && din_ready;
  assign in_len    = LEN_W'(norm_len(32'(din_len), WORD_W));
  // Left-align so the first bit to send always sits in the MSB; unused bits fall off.
  assign in_word   = din << (LEN_W'(WORD_W) - in_len);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    pend_take   = 1'b0;
    direct_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_full) begin
          pend_take = 1'b1;
        end else if (accept) begin
          direct_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (rem_q > LEN_W'(1)) begin
          sh_d  = sh_q << 1;
          rem_d = rem_q - LEN_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pend_full) begin
            pend_take = 1'b1;
          end else if (accept) begin
            direct_load = 1'b1;
          end else begin
            state_d = S_IDLE;
            rem_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pend_take) begin
      sh_d    = pend_data;
      rem_d   = pend_len;
      state_d = S_SHIFT;
    end else if (direct_load) begin
      sh_d    = in_word;
      rem_d   = in_len;
      state_d = S_SHIFT;
    end

    pend_load = accept && !direct_load;
    x_d       = (state_d == S_SHIFT) ? sh_d[WORD_W-1] : IDLE_BIT;
    xv_d      = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_BIT;
      xv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
    end
  end

  seq_word_buf #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_pend (
    .clk       (clk),
    .rst       (rst),
    .load      (pend_load),
    .take      (pend_take),
    .load_data (in_word),
    .load_len  (in_len),
    .data      (pend_data),
    .len       (pend_len),
    .full      (pend_full)
  );

  assign x          = x_q;
  assign x_valid    = xv_q;
  assign busy       = (state_q == S_SHIFT) || pend_full;
  assign words_sent = cnt_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: table-driven single words plus hand-written
// streaming, reset and pattern-chain sequences.
module tb_seq_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = '0;
  logic [3:0]  din_len = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        x;
  logic        x_valid;
  logic        busy;
  logic [15:0] words_sent;

  always #5 clk = ~clk;

  seq_serializer #(
    .WORD_W   (8),
    .IDLE_BIT (1'b0),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_len    (din_len),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .words_sent (words_sent)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic q_bits[$];
  int   q_cyc[$];
  int   cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst && x_valid) begin
      q_bits.push_back(x);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_bits.delete();
    q_cyc.delete();
  endtask

  // Present a word and return just after the edge that accepts it; din_valid stays high.
  task automatic offer(input logic [7:0] d, input logic [3:0] l);
    logic r;
    int   n;
    n = 0;
    din = d;
    din_len = l;
    din_valid = 1'b1;
    forever begin
      r = din_ready;
      tick();
      if (r) break;
      n++;
      if (n > 50) begin
        check("offer_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp, input int n);
    logic [31:0] act;
    int sz;
    act = '0;
    sz = q_bits.size();
    check({name, "_count"}, sz, n);
    for (int i = 0; i < sz && i < 32; i++) act = {act[30:0], q_bits[i]};
    check({name, "_bits"}, act, exp);
    if (sz > 0) check({name, "_gap"}, q_cyc[sz-1] - q_cyc[0], sz - 1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [3:0] len;
    logic [7:0] exp;   // expected bits, first-sent in bit 7
    int         n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] prev;
    int hits;
    logic [3:0] win;

    vecs[0] = '{8'h09, 4'd4, 8'h90, 4};
    vecs[1] = '{8'hA5, 4'd0, 8'hA5, 8};
    vecs[2] = '{8'hA5, 4'd9, 8'hA5, 8};
    vecs[3] = '{8'hA5, 4'd15, 8'hA5, 8};
    vecs[4] = '{8'h80, 4'd1, 8'h00, 1};
    vecs[5] = '{8'h01, 4'd1, 8'h80, 1};
    vecs[6] = '{8'hFF, 4'd3, 8'hE0, 3};
    vecs[7] = '{8'h3C, 4'd6, 8'hF0, 6};

    // Reset held with a word offered.
    rst = 1'b0;
    din = 8'hFF;
    din_len = 4'd8;
    din_valid = 1'b1;
    repeat (3) tick();
    check("rst_x", {31'd0, x}, 32'd0);
    check("rst_x_valid", {31'd0, x_valid}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_words_sent", words_sent, 32'd0);
    din_valid = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    check("rst_no_spurious", q_bits.size(), 32'd0);

    // Single words with exact timing.
    for (int v = 0; v < 8; v++) begin
      prev = words_sent;
      din = vecs[v].din;
      din_len = vecs[v].len;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < vecs[v].n; i++) begin
        check($sformatf("v%0d_xvalid_b%0d", v, i), {31'd0, x_valid}, 32'd1);
        check($sformatf("v%0d_x_b%0d", v, i), {31'd0, x}, {31'd0, vecs[v].exp[7-i]});
        tick();
      end
      check($sformatf("v%0d_end_xvalid", v), {31'd0, x_valid}, 32'd0);
      check($sformatf("v%0d_end_x", v), {31'd0, x}, 32'd0);
      check($sformatf("v%0d_end_busy", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_words", v), words_sent, {16'd0, prev + 16'd1});
    end

    // Back-to-back through the pending buffer.
    clear_q();
    prev = words_sent;
    offer(8'h08, 4'd4);
    check("b2b_ready_first", {31'd0, din_ready}, 32'd1);
    offer(8'h08, 4'd4);
    check("b2b_ready_pend_full", {31'd0, din_ready}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    din_valid = 1'b0;
    wait_idle();
    check_stream("b2b", 32'h88, 8);
    check("b2b_words", words_sent, {16'd0, prev + 16'd2});

    // Accept on the retiring edge with pending empty goes straight to the shifter.
    clear_q();
    offer(8'h01, 4'd1);
    offer(8'hFE, 4'd1);
    check("direct_ready", {31'd0, din_ready}, 32'd1);
    offer(8'h03, 4'd1);
    check("direct_ready2", {31'd0, din_ready}, 32'd1);
    din_valid = 1'b0;
    wait_idle();
    check_stream("direct", 32'h5, 3);

    // Reset in the middle of a word.
    offer(8'hF0, 4'd8);
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_x", {31'd0, x}, 32'd0);
    check("midrst_x_valid", {31'd0, x_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, din_ready}, 32'd1);
    check("midrst_words", words_sent, 32'd0);
    tick();
    rst = 1'b1;
    clear_q();
    tick();
    offer(8'hC3, 4'd8);
    din_valid = 1'b0;
    wait_idle();
    check_stream("postrst", 32'hC3, 8);
    check("postrst_words", words_sent, 32'd1);

    // Stream of 1000 patterns as a downstream checker would see it.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_q();
    tick();
    for (int k = 0; k < 8; k++) offer(8'h08, 4'd4);
    din_valid = 1'b0;
    wait_idle();
    check_stream("chain", 32'h8888_8888, 32);
    hits = 0;
    win = '0;
    foreach (q_bits[i]) begin
      win = {win[2:0], q_bits[i]};
      if (win == 4'b1000) hits++;
    end
    check("chain_hits", hits, 32'd8);
    check("chain_words", words_sent, 32'd8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
